// File: rtl/hwpe_stream_tcdm_load_arbiter_if.sv
// TCDM request/response bundle: 32-bit address/data, 4-bit byte enable.
// The master side issues requests and receives grants and in-order responses.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_load_arbiter.sv
// Shares one read-only TCDM port between NB_IN load requesters; an ID FIFO routes in-order responses back.
// Define HWPE_STREAM_TCDM_LOAD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module hwpe_stream_tcdm_load_arbiter #(
    parameter int unsigned NB_IN         = 2,
    parameter int unsigned ID_FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    hwpe_stream_intf_tcdm.slave  tcdm_slave [NB_IN-1:0],
    hwpe_stream_intf_tcdm.master tcdm_master,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int unsigned SEL_W = $clog2(NB_IN);
    localparam int unsigned PTR_W = $clog2(ID_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [NB_IN-1:0] req_vec;
    logic [31:0]      add_vec [NB_IN];
    logic [NB_IN-1:0] unused_slave_bits;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] head;
    logic             id_full;
    logic             id_empty;
    logic             push;
    logic             pop;
    logic             spurious;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] id_mem_q [ID_FIFO_DEPTH];
    logic [SEL_W-1:0] id_mem_d [ID_FIFO_DEPTH];
    logic             err_q, err_d;

    for (genvar i = 0; i < int'(NB_IN); i++) begin : g_slave
        assign req_vec[i]              = tcdm_slave[i].req;
        assign add_vec[i]              = tcdm_slave[i].add;
        assign unused_slave_bits[i]    = ^{tcdm_slave[i].wen, tcdm_slave[i].be, tcdm_slave[i].data};
        assign tcdm_slave[i].gnt       = push && (sel == SEL_W'(i));
        assign tcdm_slave[i].r_valid   = pop && (head == SEL_W'(i));
        assign tcdm_slave[i].r_data    = tcdm_master.r_data;
    end

`ifdef HWPE_STREAM_TCDM_LOAD_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int k = int'(NB_IN) - 1; k >= 0; k--) begin
            if (req_vec[k]) sel = SEL_W'(k);
        end
    end
`else
    logic [SEL_W-1:0]   rr_q, rr_d;
    logic [2*NB_IN-1:0] req_rot;
    int                 sel_sum;

    // Rotate so bit k is requester (rr_q + k); scanning downward leaves the first hit at or after rr_q.
    always_comb begin
        req_rot = {req_vec, req_vec} >> rr_q;
        sel_sum = 0;
        sel     = '0;
        for (int k = int'(NB_IN) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel_sum = int'(rr_q) + k;
                if (sel_sum >= int'(NB_IN)) sel_sum = sel_sum - int'(NB_IN);
                sel = SEL_W'(sel_sum);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push) rr_d = (sel == SEL_W'(NB_IN - 1)) ? '0 : sel + SEL_W'(1);
        if (clear_i) rr_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_q <= '0;
        else         rr_q <= rr_d;
    end
`endif

    assign head     = id_mem_q[rd_ptr_q];
    assign id_full  = (cnt_q == CNT_W'(ID_FIFO_DEPTH));
    assign id_empty = (cnt_q == '0);

    // A full ID FIFO blocks requests outright, even when a pop happens in the same cycle.
    assign tcdm_master.req  = (|req_vec) & ~id_full;
    assign tcdm_master.add  = add_vec[sel];
    assign tcdm_master.wen  = 1'b1;
    assign tcdm_master.be   = 4'hf;
    assign tcdm_master.data = '0;

    assign push     = tcdm_master.req & tcdm_master.gnt;
    assign pop      = tcdm_master.r_valid & ~id_empty;
    assign spurious = tcdm_master.r_valid & id_empty;

    assign busy_o = ~id_empty;
    assign err_o  = err_q;

    always_comb begin
        id_mem_d = id_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | spurious;
        if (push) begin
            id_mem_d[wr_ptr_q] = sel;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(ID_FIFO_DEPTH); i++) id_mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            id_mem_q <= id_mem_d;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_tcdm_load_arbiter.sv
// Randomized and directed bench for the TCDM load arbiter against a queue-based reference model.
module tb_hwpe_stream_tcdm_load_arbiter;
    localparam int NB    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [NB-1:0] s_req;
    logic [31:0]   s_add [NB];
    logic [NB-1:0] s_gnt;
    logic [NB-1:0] s_rv;
    logic [31:0]   s_rdata [NB];
    logic          m_req, m_gnt, m_rv, m_wen;
    logic [31:0]   m_add, m_rdata, m_data;
    logic [3:0]    m_be;
    logic          busy, err;

    hwpe_stream_intf_tcdm slv [NB-1:0] ();
    hwpe_stream_intf_tcdm mst ();

    for (genvar i = 0; i < NB; i++) begin : g_drv
        assign slv[i].req  = s_req[i];
        assign slv[i].add  = s_add[i];
        assign slv[i].wen  = 1'b0;
        assign slv[i].be   = 4'h0;
        assign slv[i].data = s_add[i] ^ 32'h5555_5555;
        assign s_gnt[i]    = slv[i].gnt;
        assign s_rv[i]     = slv[i].r_valid;
        assign s_rdata[i]  = slv[i].r_data;
    end

    assign mst.gnt     = m_gnt;
    assign mst.r_valid = m_rv;
    assign mst.r_data  = m_rdata;
    assign m_req       = mst.req;
    assign m_add       = mst.add;
    assign m_wen       = mst.wen;
    assign m_be        = mst.be;
    assign m_data      = mst.data;

    hwpe_stream_tcdm_load_arbiter #(.NB_IN(NB), .ID_FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .tcdm_slave  (slv),
        .tcdm_master (mst),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: outstanding requester IDs in issue order, priority pointer, sticky error
    int idq [$];
    int rr   = 0;
    bit merr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        idq.delete();
        rr   = 0;
        merr = 1'b0;
    endtask

    // One cycle: drive after the falling edge, check combinational and registered outputs, advance the model.
    task automatic step(input logic [NB-1:0] rq, input bit g, input bit rv, input logic [31:0] rd, input bit clr);
        int  sel;
        int  head;
        bit  mreq;
        bit  hs;
        @(negedge clk);
        s_req = rq;
        for (int i = 0; i < NB; i++) s_add[i] = $urandom;
        m_gnt   = g;
        m_rv    = rv;
        m_rdata = rd;
        clear   = clr;
        #1;
        mreq = (rq != '0) && (idq.size() < DEPTH);
        sel  = 0;
        for (int k = 0; k < NB; k++) begin
            int c;
            c = (rr + k) % NB;
            if (rq[c]) begin
                sel = c;
                break;
            end
        end
        hs   = mreq && g;
        head = (idq.size() > 0) ? idq[0] : -1;
        check("m_req", m_req, mreq);
        if (mreq) check("m_add", m_add, s_add[sel]);
        check("m_wen", m_wen, 1);
        check("m_be", m_be, 4'hf);
        check("m_data", m_data, 0);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("gnt%0d", i), s_gnt[i], hs && (i == sel));
            check($sformatf("rvalid%0d", i), s_rv[i], rv && (i == head));
            if (rv) check($sformatf("rdata%0d", i), s_rdata[i], rd);
        end
        check("busy", busy, idq.size() != 0);
        check("err", err, merr);
        if (rv) begin
            if (idq.size() > 0) void'(idq.pop_front());
            else merr = 1'b1;
        end
        if (hs) begin
            idq.push_back(sel);
`ifndef HWPE_STREAM_TCDM_LOAD_ARB_FIXED_PRIO_EN
            rr = (sel + 1) % NB;
`endif
        end
        if (clr) model_reset();
    endtask

    task automatic drain();
        while (idq.size() > 0) step('0, 1'b0, 1'b1, $urandom, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pg [4] = '{100, 70, 30, 90};
        int pr [4] = '{100, 40, 80, 20};
        rst_n   = 1'b0;
        clear   = 1'b0;
        s_req   = '0;
        m_gnt   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = '0;
        for (int i = 0; i < NB; i++) s_add[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_mreq", m_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // both requesters busy, grant every cycle, each response one cycle after its grant
        repeat (12) step('1, 1'b1, idq.size() > 0, $urandom, 1'b0);
        drain();

        // fill the ID FIFO, then one response; grants resume the cycle after
        repeat (10) step('1, 1'b1, 1'b0, '0, 1'b0);
        step('1, 1'b1, 1'b1, $urandom, 1'b0);
        step('1, 1'b1, 1'b0, '0, 1'b0);

        // push and pop together at count 3
        while (idq.size() > 3) step('0, 1'b0, 1'b1, $urandom, 1'b0);
        step('1, 1'b1, 1'b1, $urandom, 1'b0);
        step('0, 1'b0, 1'b0, '0, 1'b0);
        drain();

        // spurious response, sticky until clear
        step('0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        repeat (3) step(2'b01, 1'b0, 1'b0, '0, 1'b0);
        step('0, 1'b0, 1'b0, '0, 1'b1);
        step('0, 1'b0, 1'b0, '0, 1'b0);

        // stall with requester 1 selected while requester 0 also asks
        step(2'b01, 1'b1, 1'b0, '0, 1'b0);
        repeat (5) step(2'b11, 1'b0, 1'b0, '0, 1'b0);
        step(2'b11, 1'b1, 1'b0, '0, 1'b0);
        step(2'b11, 1'b1, 1'b0, '0, 1'b0);
        drain();

        // random traffic with occasional stray responses and clears
        for (int ph = 0; ph < 4; ph++) begin
            repeat (300) begin
                logic [NB-1:0] rq;
                bit g, rv, clr;
                rq  = NB'($urandom);
                g   = ($urandom_range(99) < pg[ph]);
                rv  = ($urandom_range(99) < pr[ph]) && (idq.size() > 0 || $urandom_range(49) == 0);
                clr = ($urandom_range(199) == 0);
                step(rq, g, rv, $urandom, clr);
            end
            drain();
            step('0, 1'b0, 1'b0, '0, 1'b1);
        end

        // reset with four loads outstanding and err set
        step('0, 1'b0, 1'b1, $urandom, 1'b0);
        repeat (4) step('1, 1'b1, 1'b0, '0, 1'b0);
        check("pre_rst_err", err, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        model_reset();
        s_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step('1, 1'b1, idq.size() > 0, $urandom, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_tcdm_load_arbiter.md
# hwpe_stream_tcdm_load_arbiter

Shares one read-only TCDM master port between `NB_IN` load requesters, typically several streamers placed in front of a single TCDM load FIFO stage. It arbitrates requests round-robin and records the winner's index in an ID FIFO. It then routes each in-order `r_valid`/`r_data` response back to the requester that issued it. Responses may arrive with any latency of at least one cycle, provided they stay in order.

## Interface
Parameters:
- `NB_IN`, 2: number of requester ports (≥2).
- `ID_FIFO_DEPTH`, 8: maximum outstanding granted loads (power of two, ≥2).

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous clear of all state.
- `tcdm_slave[NB_IN-1:0]`  `hwpe_stream_intf_tcdm.slave`  add/data 32, be 4  requester ports.
- `tcdm_master`  `hwpe_stream_intf_tcdm.master`  add/data 32, be 4  shared port toward TCDM/load FIFO.
- `busy_o`  out  1  high while ≥1 load is outstanding (ID count ≠ 0).
- `err_o`  out  1  sticky: `r_valid` received with the ID FIFO empty.

## Operation
- Requester `wen`, `be` and `data` are ignored. The master drives `wen='1`, `be='1` and `data='0`.
- Eligible set: slaves with `req=1`. `tcdm_master.req = |req & ~id_full`. `tcdm_master.add` is the selected slave's `add`.
- Selection is round-robin. Pointer `rr_q` holds the highest-priority index. The first eligible index at or after `rr_q` (wrapping modulo `NB_IN`) is selected.
- `tcdm_slave[sel].gnt = tcdm_master.gnt & tcdm_master.req`. All other slave `gnt` signals are 0.
- Handshake occurs when `master.req & master.gnt`. On a handshake:
  - `sel` is pushed into the ID FIFO.
  - `rr_q` is set to `(sel+1) mod NB_IN`.
- Without a handshake, `rr_q` holds. A waiting requester therefore keeps its selection until granted.
- On `tcdm_master.r_valid`:
  - The ID FIFO head `h` is popped.
  - `tcdm_slave[h].r_valid = 1` and `tcdm_slave[h].r_data = master.r_data`.
  - All other slaves see `r_valid=0`. Every slave's `r_data` carries `master.r_data` unconditionally.
- If `r_valid` arrives while the ID FIFO is empty:
  - No slave `r_valid` is asserted and no pop occurs.
  - `err_o` is set and stays set until reset or `clear_i`.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- ID FIFO full (count = `ID_FIFO_DEPTH`): master `req` is forced to 0, so all slave `gnt` are 0. There is no same-cycle bypass, even if a pop occurs in that cycle.
- An empty ID FIFO with a simultaneous push and `r_valid` is still an error: the response cannot belong to the same-cycle grant.
- Counter widths: pointers are `$clog2(ID_FIFO_DEPTH)` bits with natural wrap. The count is `$clog2(ID_FIFO_DEPTH)+1` bits.
- `clear_i` or reset clears the ID FIFO pointers and count, sets `rr_q=0` and clears `err_o`.
  - Loads still in flight at that moment are forgotten. Their later responses raise `err_o`. Callers must drain before clearing.

## Timing
- Arbitration and grant are combinational, with zero cycles from slave `req` to master `req` and from master `gnt` to slave `gnt`.
- Response routing is combinational, with zero cycles from master `r_valid` to slave `r_valid`.
- ID push and pop take effect at the next rising edge.
- `busy_o` and `err_o` are registered-derived. Both are 0 after reset.
- All slave `gnt`/`r_valid` and master `req` are 0 while in reset, because every requester `req` is 0 or the ID state is cleared.
- Throughput: one grant per cycle while the ID FIFO is not full.

## Configuration
- `HWPE_STREAM_TCDM_LOAD_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest eligible index always wins. `rr_q` is removed, and starvation is possible by design.
  - Undefined (default): round-robin as specified above.

## Test plan
- Round-robin sharing:
  - Stimulus: `NB_IN=2`, both `req` held high, master `gnt=1` every cycle, each response 1 cycle after its grant.
  - Required: grants alternate 0,1,0,1; each `r_data` arrives only at the requester that issued the address.
- ID FIFO full (`ID_FIFO_DEPTH=8`):
  - Stimulus: 8 grants issued with `r_valid` held low.
  - Required: master `req=0`, `busy_o=1`, and no slave `gnt`.
  - Then: one `r_valid` pulse leaves master `req` low that same cycle; grants resume the next cycle.
- Simultaneous push and pop:
  - Stimulus: count=3 with a grant and an `r_valid` in the same cycle.
  - Required: count stays 3; the response goes to the oldest ID.
- Spurious response:
  - Stimulus: `r_valid` with the ID FIFO empty and data `32'hDEAD_BEEF`.
  - Required: no slave `r_valid`; `err_o=1` next cycle and held until `clear_i`.
- Stall stability:
  - Stimulus: slave 1 selected with master `gnt=0` for 5 cycles while slave 0 raises `req`.
  - Required: master `add` stays at slave 1's address until granted; then slave 0 is granted next.
- Reset mid-operation:
  - Stimulus: assert `rst_ni=0` with 4 loads outstanding.
  - Required: `busy_o=0` immediately and `err_o=0`; after release, the first grant goes to index 0.
